// File: rtl/stb_dbus_arbiter.sv
// Arbitrates the single data-cache port between LSU loads and store-buffer drain writes.
// Loads win by default; stores win on STB full, load alias, starvation limit or flush.
module stb_dbus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu2arb_ld_req,
  input  logic [ADDR_W-1:0]   lsu2arb_ld_addr,
  output logic                arb2lsu_ld_ack,
  output logic [DATA_W-1:0]   arb2lsu_ld_rdata,
  input  logic                stb2arb_req,
  input  logic [ADDR_W-1:0]   stb2arb_addr,
  input  logic [DATA_W-1:0]   stb2arb_wdata,
  input  logic [DATA_W/8-1:0] stb2arb_sel,
  input  logic                stb2arb_full,
  input  logic                stb2arb_ld_hazard,
  output logic                arb2stb_ack,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                arb2cache_req,
  output logic                arb2cache_w_en,
  output logic [ADDR_W-1:0]   arb2cache_addr,
  output logic [DATA_W-1:0]   arb2cache_wdata,
  output logic [DATA_W/8-1:0] arb2cache_sel,
  input  logic                cache2arb_ack,
  input  logic [DATA_W-1:0]   cache2arb_rdata
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LD_WAIT = 2'd1,
    S_ST_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic               r_req;
  logic               r_w_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [SEL_W-1:0]   r_sel;

  logic w_idle;
  logic w_starved;
  logic w_st_prio;
  logic w_grant_st;
  logic w_grant_ld;

  // Grant decisions are only made in IDLE; loads never go out while a fence is pending.
  assign w_idle     = (r_state == S_IDLE);
  assign w_starved  = (r_starve_cnt == CNT_W'(STARVE_MAX));
  assign w_st_prio  = stb2arb_full | stb2arb_ld_hazard | flush_req | w_starved;
  assign w_grant_st = w_idle & stb2arb_req & (w_st_prio | ~lsu2arb_ld_req);
  assign w_grant_ld = w_idle & ~w_grant_st & lsu2arb_ld_req & ~flush_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_req        <= 1'b0;
      r_w_en       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sel        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_st) begin
            r_state      <= S_ST_WAIT;
            r_req        <= 1'b1;
            r_w_en       <= 1'b1;
            r_addr       <= stb2arb_addr;
            r_wdata      <= stb2arb_wdata;
            r_sel        <= stb2arb_sel;
            r_starve_cnt <= '0;
          end else if (w_grant_ld) begin
            r_state <= S_LD_WAIT;
            r_req   <= 1'b1;
            r_w_en  <= 1'b0;
            r_addr  <= lsu2arb_ld_addr;
            r_wdata <= '0;
            r_sel   <= '1;
            // Count loads that jump ahead of a waiting store, saturating at the limit.
            if (!stb2arb_req) begin
              r_starve_cnt <= '0;
            end else if (!w_starved) begin
              r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
          end else if (!stb2arb_req) begin
            r_starve_cnt <= '0;
          end
        end
        S_LD_WAIT, S_ST_WAIT: begin
          if (cache2arb_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_w_en  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign arb2cache_req    = r_req;
  assign arb2cache_w_en   = r_w_en;
  assign arb2cache_addr   = r_addr;
  assign arb2cache_wdata  = r_wdata;
  assign arb2cache_sel    = r_sel;

  // Owner acks follow the cache ack in the same cycle.
  assign arb2lsu_ld_ack   = (r_state == S_LD_WAIT) & cache2arb_ack;
  assign arb2stb_ack      = (r_state == S_ST_WAIT) & cache2arb_ack;
  assign arb2lsu_ld_rdata = cache2arb_rdata;
  assign flush_done       = flush_req & ~stb2arb_req & w_idle;

endmodule
